// File: rtl/fifo_write_arbiter_if.sv
// Requester-side and FIFO-side write handshake shared by fifo_write_arbiter.
// The arbiter takes the master modport; requesters and the FIFO take the slave side.
interface fifo_write_arbiter_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     space_available;
    logic [WIDTH-1:0]         write_data;
    logic                     write_strobe;

    modport master (
        input  req_valid,
        input  req_last,
        input  req_data,
        input  space_available,
        output req_ready,
        output write_data,
        output write_strobe
    );

    modport slave (
        output req_valid,
        output req_last,
        output req_data,
        output space_available,
        input  req_ready,
        input  write_data,
        input  write_strobe
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_ARB_HEADER_EN to prefix every packet with a header beat carrying the grant index.
module fifo_write_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_write_arbiter_if.master  bus,
    output logic                  busy,
    output logic [IDX_BITS-1:0]   grant_id,
    output logic [15:0]           packet_count
);

    localparam logic [1:0] StIdle = 2'd0;
`ifdef FIFO_ARB_HEADER_EN
    localparam logic [1:0] StHdr  = 2'd1;
`endif
    localparam logic [1:0] StBusy = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IDX_BITS-1:0] grant_q, grant_d;
    logic [IDX_BITS-1:0] last_q, last_d;
    logic [15:0]         count_q, count_d;
    logic [IDX_BITS-1:0] pick;
    logic [IDX_BITS-1:0] idx;
    logic [WIDTH-1:0]    sel_data;
    logic                fire;

`ifdef FIFO_ARB_HEADER_EN
    logic [WIDTH-1:0] hdr;

    always_comb begin
        hdr                = '0;
        hdr[WIDTH-1]       = 1'b1;
        hdr[IDX_BITS-1:0]  = grant_q;
    end
`endif

    // Scan from the farthest candidate back to last_q+1 so the nearest valid one wins.
    always_comb begin
        pick = last_q;
        idx  = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            idx = IDX_BITS'((int'(last_q) + k) % int'(NUM_REQ));
            if (bus.req_valid[idx]) begin
                pick = idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q == IDX_BITS'(i)) begin
                sel_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.req_ready    = '0;
        bus.write_data   = '0;
        bus.write_strobe = 1'b0;
        fire             = 1'b0;
        case (state_q)
`ifdef FIFO_ARB_HEADER_EN
            StHdr: begin
                bus.write_data   = hdr;
                bus.write_strobe = bus.space_available;
            end
`endif
            StBusy: begin
                bus.req_ready[grant_q] = bus.space_available;
                bus.write_data         = sel_data;
                fire                   = bus.req_valid[grant_q] & bus.space_available;
                bus.write_strobe       = fire;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (|bus.req_valid) begin
                    grant_d = pick;
`ifdef FIFO_ARB_HEADER_EN
                    state_d = StHdr;
`else
                    state_d = StBusy;
`endif
                end
            end
`ifdef FIFO_ARB_HEADER_EN
            StHdr: begin
                if (bus.space_available) begin
                    state_d = StBusy;
                end
            end
`endif
            StBusy: begin
                if (fire && bus.req_last[grant_q]) begin
                    last_d  = grant_q;
                    count_d = count_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IDX_BITS'(NUM_REQ - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign grant_id     = grant_q;
    assign packet_count = count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: vector table, corner-case sequences and a
// randomized run against a packet-level reference model.
module tb_fifo_write_arbiter;

    localparam int W = 8;
    localparam int N = 4;
`ifdef FIFO_ARB_HEADER_EN
    localparam bit HdrEn = 1'b1;
`else
    localparam bit HdrEn = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] packet_count;

    fifo_write_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

    fifo_write_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .grant_id     (grant_id),
        .packet_count (packet_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        space;
        logic [3:0]  ready;
        logic        strobe;
        logic [7:0]  wdata;
        logic        busy;
        logic [1:0]  grant;
        logic [15:0] count;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                         input logic s);
        bus.req_valid       = v;
        bus.req_last        = l;
        bus.req_data        = d;
        bus.space_available = s;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Leaves the bench at a negedge with req_ready[i] high, or records a timeout.
    task automatic wait_ready(input logic [1:0] i, input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready[i] && n < 8) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, bus.req_ready[i]}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[15];
        bit          act;
        logic [1:0]  own;
        logic [1:0]  last_g;
        logic [1:0]  egrant;
        bit          hdr_ph;
        int          pcount;
        logic [7:0]  cur[N];
        int          rem[N];
        logic [3:0]  v, l, er;
        logic [31:0] d;
        logic        s, es, eb;
        logic [7:0]  ed;
        logic [1:0]  j;

        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_strobe", {31'd0, bus.write_strobe}, 32'd0);
        check("reset_ready", {28'd0, bus.req_ready}, 32'd0);
        check("reset_grant", {30'd0, grant_id}, 32'd0);
        check("reset_count", {16'd0, packet_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifndef FIFO_ARB_HEADER_EN
        // Single 3-beat packet, a stalled 2-beat packet, then 4-way contention.
        tbl[0]  = '{4'b0001, 4'b0000, 32'h000000A1, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 16'd0};
        tbl[1]  = '{4'b0001, 4'b0000, 32'h000000A1, 1'b1, 4'b0001, 1'b1, 8'hA1, 1'b1, 2'd0, 16'd0};
        tbl[2]  = '{4'b0001, 4'b0000, 32'h000000A2, 1'b1, 4'b0001, 1'b1, 8'hA2, 1'b1, 2'd0, 16'd0};
        tbl[3]  = '{4'b0001, 4'b0001, 32'h000000A3, 1'b1, 4'b0001, 1'b1, 8'hA3, 1'b1, 2'd0, 16'd0};
        tbl[4]  = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 16'd1};
        tbl[5]  = '{4'b0010, 4'b0000, 32'h0000B100, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 16'd1};
        tbl[6]  = '{4'b0010, 4'b0000, 32'h0000B100, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd1, 16'd1};
        tbl[7]  = '{4'b0010, 4'b0000, 32'h0000B100, 1'b1, 4'b0010, 1'b1, 8'hB1, 1'b1, 2'd1, 16'd1};
        tbl[8]  = '{4'b0010, 4'b0010, 32'h0000B200, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd1, 16'd1};
        tbl[9]  = '{4'b0010, 4'b0010, 32'h0000B200, 1'b1, 4'b0010, 1'b1, 8'hB2, 1'b1, 2'd1, 16'd1};
        tbl[10] = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd1, 16'd2};
        tbl[11] = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd1, 16'd2};
        tbl[12] = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 1'b1, 4'b0100, 1'b1, 8'hC2, 1'b1, 2'd2, 16'd2};
        tbl[13] = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2, 16'd3};
        tbl[14] = '{4'b1111, 4'b1111, 32'hD3C2B1A0, 1'b1, 4'b1000, 1'b1, 8'hD3, 1'b1, 2'd3, 16'd3};
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].valid, tbl[i].last, tbl[i].data, tbl[i].space);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), {28'd0, bus.req_ready}, {28'd0, tbl[i].ready});
            check($sformatf("vec%0d_strobe", i), {31'd0, bus.write_strobe}, {31'd0, tbl[i].strobe});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
            check($sformatf("vec%0d_grant", i), {30'd0, grant_id}, {30'd0, tbl[i].grant});
            check($sformatf("vec%0d_count", i), {16'd0, packet_count}, {16'd0, tbl[i].count});
            if (tbl[i].strobe) begin
                check($sformatf("vec%0d_data", i), {24'd0, bus.write_data}, {24'd0, tbl[i].wdata});
            end
            @(posedge clk);
            #1;
        end
`else
        // Header build: requester 3 sends one beat, header stalls on a full FIFO first.
        drive(4'b1000, 4'b1000, 32'h5A000000, 1'b0);
        @(negedge clk);
        check("hdr_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hdr_wait_busy", {31'd0, busy}, 32'd1);
            check("hdr_wait_grant", {30'd0, grant_id}, 32'd3);
            check("hdr_wait_strobe", {31'd0, bus.write_strobe}, 32'd0);
            check("hdr_wait_ready", {28'd0, bus.req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        drive(4'b1000, 4'b1000, 32'h5A000000, 1'b1);
        @(negedge clk);
        check("hdr_strobe", {31'd0, bus.write_strobe}, 32'd1);
        check("hdr_data", {24'd0, bus.write_data}, 32'h83);
        check("hdr_ready", {28'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hdr_beat_strobe", {31'd0, bus.write_strobe}, 32'd1);
        check("hdr_beat_data", {24'd0, bus.write_data}, 32'h5A);
        check("hdr_beat_ready", {28'd0, bus.req_ready}, 32'b1000);
        @(posedge clk);
        #1;
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        check("hdr_done_busy", {31'd0, busy}, 32'd0);
        check("hdr_done_count", {16'd0, packet_count}, 32'd1);
        @(posedge clk);
        #1;
`endif

        // Bubble: requester 1 holds its grant while idle and requester 2 waits.
        do_reset();
        drive(4'b0010, 4'b0000, 32'h0000B100, 1'b1);
        wait_ready(2'd1, "bub_ready1");
        check("bub_b1_strobe", {31'd0, bus.write_strobe}, 32'd1);
        check("bub_b1_data", {24'd0, bus.write_data}, 32'hB1);
        @(posedge clk);
        #1;
        drive(4'b0100, 4'b0000, 32'h00C0B200, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bub_hold_grant", {30'd0, grant_id}, 32'd1);
            check("bub_hold_busy", {31'd0, busy}, 32'd1);
            check("bub_hold_strobe", {31'd0, bus.write_strobe}, 32'd0);
            check("bub_hold_ready", {28'd0, bus.req_ready}, 32'b0010);
            @(posedge clk);
            #1;
        end
        drive(4'b0110, 4'b0110, 32'h00C0B200, 1'b1);
        @(negedge clk);
        check("bub_b2_strobe", {31'd0, bus.write_strobe}, 32'd1);
        check("bub_b2_data", {24'd0, bus.write_data}, 32'hB2);
        @(posedge clk);
        #1;
        drive(4'b0100, 4'b0100, 32'h00C0B200, 1'b1);
        wait_ready(2'd2, "bub_ready2");
        check("bub_r2_grant", {30'd0, grant_id}, 32'd2);
        check("bub_r2_data", {24'd0, bus.write_data}, 32'hC0);
        @(posedge clk);
        #1;
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        check("bub_count", {16'd0, packet_count}, 32'd2);
        @(posedge clk);
        #1;

        // Reset during beat 2 of requester 2's packet.
        drive(4'b0100, 4'b0000, 32'h00C10000, 1'b1);
        wait_ready(2'd2, "rst_ready2");
        @(posedge clk);
        #1;
        drive(4'b0100, 4'b0000, 32'h00C20000, 1'b1);
        @(negedge clk);
        check("rst_beat2_strobe", {31'd0, bus.write_strobe}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobe", {31'd0, bus.write_strobe}, 32'd0);
        check("rst_ready", {28'd0, bus.req_ready}, 32'd0);
        check("rst_count", {16'd0, packet_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(4'b1111, 4'b0000, 32'hD0C0B0A0, 1'b1);
        @(negedge clk);
        check("rst_arb_idle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_arb_grant", {30'd0, grant_id}, 32'd0);
        check("rst_arb_busy", {31'd0, busy}, 32'd1);

        // Randomized traffic against a packet-level model.
        do_reset();
        act    = 1'b0;
        own    = 2'd0;
        last_g = 2'd3;
        egrant = 2'd0;
        hdr_ph = 1'b0;
        pcount = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = int'($urandom_range(1, 4));
            cur[i] = 8'($urandom);
        end
        for (int c = 0; c < 1500; c++) begin
            v = '0;
            l = '0;
            d = '0;
            for (int i = 0; i < N; i++) begin
                v[i]         = ($urandom_range(0, 3) != 0);
                l[i]         = (rem[i] == 1);
                d[i*8 +: 8]  = cur[i];
            end
            s = ($urandom_range(0, 3) != 0);
            drive(v, l, d, s);

            er = '0;
            es = 1'b0;
            ed = 8'h00;
            eb = act;
            if (act) begin
                if (hdr_ph) begin
                    es = s;
                    ed = 8'h80 | {6'd0, own};
                end else begin
                    er[own] = s;
                    es      = v[own] & s;
                    ed      = cur[own];
                end
            end

            @(negedge clk);
            check("rnd_ready", {28'd0, bus.req_ready}, {28'd0, er});
            check("rnd_strobe", {31'd0, bus.write_strobe}, {31'd0, es});
            check("rnd_busy", {31'd0, busy}, {31'd0, eb});
            check("rnd_grant", {30'd0, grant_id}, {30'd0, egrant});
            check("rnd_count", {16'd0, packet_count}, 32'(pcount & 16'hFFFF));
            if (es) begin
                check("rnd_data", {24'd0, bus.write_data}, {24'd0, ed});
            end

            if (!act) begin
                for (int k = 1; k <= N; k++) begin
                    j = 2'((int'(last_g) + k) % N);
                    if (!act && v[j]) begin
                        act    = 1'b1;
                        own    = j;
                        egrant = j;
                        hdr_ph = HdrEn;
                    end
                end
            end else if (hdr_ph) begin
                if (s) hdr_ph = 1'b0;
            end else if (es && l[own]) begin
                last_g = own;
                pcount++;
                act    = 1'b0;
            end

            for (int i = 0; i < N; i++) begin
                if (v[i] && er[i]) begin
                    rem[i]--;
                    cur[i] = 8'($urandom);
                    if (rem[i] == 0) rem[i] = int'($urandom_range(1, 4));
                end
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
